// File: rtl/mod_inverse_if.sv
// Request/response bundle for the modular-inverse engine.
// The requester drives start/e/phi; the engine returns d/err with busy/finish status.
interface mod_inverse_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     e;
    logic [2*WIDTH-1:0]   phi;
    logic [2*WIDTH-1:0]   d;
    logic                 err;
    logic                 busy;
    logic                 finish;

    modport master (
        output start, e, phi,
        input  d, err, busy, finish
    );

    modport slave (
        input  start, e, phi,
        output d, err, busy, finish
    );
endinterface

// File: rtl/mod_inverse.sv
// Modular inverse d = e^-1 mod phi via extended Euclid.
// Each quotient comes from a bit-serial restoring divider.
module mod_inverse #(
    parameter int unsigned WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    mod_inverse_if.slave bus
);
    localparam int unsigned RW = 2 * WIDTH;
    localparam int unsigned TW = 2 * WIDTH + 2;
    localparam int unsigned CW = $clog2(RW) + 1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIV,
        UPDATE,
        FIX,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [RW-1:0]        r0_q, r0_d;
    logic [RW-1:0]        r1_q, r1_d;
    logic [RW-1:0]        phi_q, phi_d;
    logic [RW-1:0]        quo_q, quo_d;
    logic [RW-1:0]        rem_q, rem_d;
    logic [RW-1:0]        d_q, d_d;
    logic signed [TW-1:0] t0_q, t0_d;
    logic signed [TW-1:0] t1_q, t1_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 finish_q, finish_d;

    logic [RW:0]          trial_c;
    logic signed [TW-1:0] qt1_c;
    logic signed [TW-1:0] t0_fix_c;
    logic                 unused_c;

    // Product is truncated to TW bits; the true value always fits there.
    assign trial_c  = {rem_q, quo_q[RW-1]};
    assign qt1_c    = signed'(TW'(quo_q)) * t1_q;
    assign t0_fix_c = t0_q + signed'(TW'(phi_q));
    assign unused_c = ^{t0_fix_c[TW-1:RW], t0_q[TW-2:RW]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            r0_q     <= '0;
            r1_q     <= '0;
            phi_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            d_q      <= '0;
            t0_q     <= '0;
            t1_q     <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            r0_q     <= r0_d;
            r1_q     <= r1_d;
            phi_q    <= phi_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            d_q      <= d_d;
            t0_q     <= t0_d;
            t1_q     <= t1_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            finish_q <= finish_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        r0_d     = r0_q;
        r1_d     = r1_q;
        phi_d    = phi_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        d_d      = d_q;
        t0_d     = t0_q;
        t1_d     = t1_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        finish_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    phi_d   = bus.phi;
                    r0_d    = bus.phi;
                    r1_d    = RW'(bus.e);
                    t0_d    = '0;
                    t1_d    = TW'(1);
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (r1_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d   = '0;
                    quo_d   = r0_q;
                    rem_d   = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                // quo_q shifts the dividend out and the quotient bits in
                if (trial_c >= {1'b0, r1_q}) begin
                    rem_d = RW'(trial_c - {1'b0, r1_q});
                    quo_d = {quo_q[RW-2:0], 1'b1};
                end else begin
                    rem_d = trial_c[RW-1:0];
                    quo_d = {quo_q[RW-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(RW - 1)) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                r0_d    = r1_q;
                r1_d    = rem_q;
                t0_d    = t1_q;
                t1_d    = t0_q - qt1_c;
                state_d = CHECK;
            end
            FIX: begin
                if (r0_q != RW'(1)) begin
                    err_d = 1'b1;
                    d_d   = '0;
                end else begin
                    err_d = 1'b0;
                    d_d   = t0_q[TW-1] ? t0_fix_c[RW-1:0] : t0_q[RW-1:0];
                end
                state_d = DONE;
            end
            DONE: begin
                finish_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) && (state_d != DONE);
    end

    assign bus.d      = d_q;
    assign bus.err    = err_q;
    assign bus.busy   = busy_q;
    assign bus.finish = finish_q;
endmodule
